// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter for the register file's single write port.
// Merges the ALU write-back source (fixed latency, no back-pressure) with the
// LSU source (valid/ready). LSU results that lose arbitration wait in a small
// in-order queue. An age counter forces the queue head through after
// STARVE_MAX lost cycles.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   alu_we/alu_rd/alu_wd         ALU write-back request
//   alu_stall                    hold request to the ALU (head is being forced out)
//   lsu_valid/lsu_ready          LSU handshake
//   lsu_rd/lsu_wd                LSU destination and data
//   WE3/A3/WD3                   registered register-file write port
//   pend                         bitmap of destinations still waiting in the queue
//   proto_err                    sticky: alu_we was asserted while alu_stall was high
//
// Optional feature: define RF_WB_X0_DROP_EN to silently consume writes to x0.
module rf_wb_arbiter #(
  parameter int A_WIDTH    = 5,
  parameter int D_WIDTH    = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  alu_we,
  input  logic [A_WIDTH-1:0]    alu_rd,
  input  logic [D_WIDTH-1:0]    alu_wd,
  output logic                  alu_stall,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [A_WIDTH-1:0]    lsu_rd,
  input  logic [D_WIDTH-1:0]    lsu_wd,
  output logic                  WE3,
  output logic [A_WIDTH-1:0]    A3,
  output logic [D_WIDTH-1:0]    WD3,
  output logic [2**A_WIDTH-1:0] pend,
  output logic                  proto_err
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AGW = $clog2(STARVE_MAX + 1);

  logic [A_WIDTH-1:0] q_rd_q [DEPTH];
  logic [A_WIDTH-1:0] q_rd_d [DEPTH];
  logic [D_WIDTH-1:0] q_wd_q [DEPTH];
  logic [D_WIDTH-1:0] q_wd_d [DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AGW-1:0]     age_q, age_d;
  logic               we3_q, we3_d, perr_q, perr_d;
  logic [A_WIDTH-1:0] a3_q, a3_d;
  logic [D_WIDTH-1:0] wd3_q, wd3_d;

  logic q_empty, hs, alu_x0, lsu_x0, alu_req, lsu_req, push, pop;
  logic [PW-1:0] off;

  always_comb begin
    q_empty   = (cnt_q == '0);
    lsu_ready = !RST && (cnt_q < CW'(DEPTH));
    alu_stall = (age_q == AGW'(STARVE_MAX));
    hs        = lsu_valid && lsu_ready;
`ifdef RF_WB_X0_DROP_EN
    alu_x0 = (alu_rd == '0);
    lsu_x0 = (lsu_rd == '0);
`else
    alu_x0 = 1'b0;
    lsu_x0 = 1'b0;
`endif
    // A dropped x0 write is consumed but does not compete for the port.
    alu_req = alu_we && !alu_x0;
    lsu_req = hs && !lsu_x0;

    push   = 1'b0;
    pop    = 1'b0;
    we3_d  = 1'b0;
    a3_d   = a3_q;
    wd3_d  = wd3_q;
    perr_d = perr_q;

    if (alu_stall) begin
      pop  = !q_empty;
      push = lsu_req;
      if (alu_we) perr_d = 1'b1;
    end else if (alu_req) begin
      we3_d = 1'b1;
      a3_d  = alu_rd;
      wd3_d = alu_wd;
      push  = lsu_req;
    end else if (!q_empty) begin
      pop  = 1'b1;
      push = lsu_req;
    end else if (lsu_req) begin
      // Empty queue: bypass straight to the port, never visible in pend.
      we3_d = 1'b1;
      a3_d  = lsu_rd;
      wd3_d = lsu_wd;
    end

    if (pop) begin
      we3_d = 1'b1;
      a3_d  = q_rd_q[head_q];
      wd3_d = q_wd_q[head_q];
    end

    q_rd_d = q_rd_q;
    q_wd_d = q_wd_q;
    if (push) begin
      q_rd_d[tail_q] = lsu_rd;
      q_wd_d[tail_q] = lsu_wd;
    end
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    head_d = pop  ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);

    if (q_empty || pop)                    age_d = '0;
    else if (age_q == AGW'(STARVE_MAX))    age_d = age_q;
    else                                   age_d = age_q + AGW'(1);

    // Slot i is live when its distance from the head is below the count.
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (CW'(off) < cnt_q) pend[q_rd_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_rd_q[i] <= '0;
        q_wd_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      age_q  <= '0;
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      q_rd_q <= q_rd_d;
      q_wd_q <= q_wd_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
      we3_q  <= we3_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      perr_q <= perr_d;
    end
  end

  assign WE3       = we3_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign proto_err = perr_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (default parameters). Inputs are driven
// 1 time unit after the rising edge; outputs are sampled there as well.
module tb_rf_wb_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic        alu_we, alu_stall, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, A3;
  logic [31:0] alu_wd, lsu_wd, WD3, pend;
  logic        WE3, proto_err;

  int checks = 0;
  int failures = 0;

  rf_wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .WE3(WE3), .A3(A3), .WD3(WD3), .pend(pend), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, WE3, we);
    chk({tag, ".a3"}, A3, a);
    chk({tag, ".wd3"}, WD3, d);
  endtask

  initial begin
    RST = 1'b1; alu_we = 0; alu_rd = 0; alu_wd = 0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'h99;

    // Reset held two cycles with lsu_valid high
    repeat (2) begin
      tick();
      chk("rst.ready", lsu_ready, 0);
      wr("rst", 0, 0, 0);
      chk("rst.pend", pend, 0);
      chk("rst.stall", alu_stall, 0);
      chk("rst.perr", proto_err, 0);
    end
    RST = 1'b0; lsu_valid = 1'b0;
    tick();
    chk("post_rst.ready", lsu_ready, 1);
    chk("post_rst.we", WE3, 0);
    chk("post_rst.pend", pend, 0);

    // Bypass
    lsu_valid = 1; lsu_rd = 5; lsu_wd = 32'hDEADBEEF;
    #1 chk("byp.pend_pre", pend, 0);
    tick(); lsu_valid = 0;
    wr("byp", 1, 5, 32'hDEADBEEF);
    chk("byp.pend", pend, 0);
    tick();
    wr("byp.idle", 0, 5, 32'hDEADBEEF);

    // Conflict: ALU wins, LSU queued one cycle
    alu_we = 1; alu_rd = 3; alu_wd = 32'h11;
    lsu_valid = 1; lsu_rd = 7; lsu_wd = 32'h22;
    tick(); alu_we = 0; lsu_valid = 0;
    wr("cfl.alu", 1, 3, 32'h11);
    chk("cfl.pend7", pend, 32'h80);
    tick();
    wr("cfl.lsu", 1, 7, 32'h22);
    chk("cfl.pend0", pend, 0);
    tick();
    chk("cfl.idle", WE3, 0);

    // Full queue
    alu_we = 1; alu_rd = 1; alu_wd = 32'hA1;
    lsu_valid = 1; lsu_rd = 10; lsu_wd = 32'hB0;
    tick();
    chk("full.ready1", lsu_ready, 1);
    alu_rd = 2; alu_wd = 32'hA2; lsu_rd = 11; lsu_wd = 32'hB1;
    tick();
    chk("full.ready0", lsu_ready, 0);
    chk("full.pend", pend, 32'h0000_0C00);
    alu_rd = 3; alu_wd = 32'hA3; lsu_rd = 12; lsu_wd = 32'hB2;
    tick();
    chk("full.ready_hold", lsu_ready, 0);
    chk("full.pend_hold", pend, 32'h0000_0C00);
    wr("full.alu", 1, 3, 32'hA3);
    alu_we = 0; lsu_valid = 0;
    tick();
    wr("full.pop0", 1, 10, 32'hB0);
    chk("full.pend1", pend, 32'h0000_0800);
    tick();
    wr("full.pop1", 1, 11, 32'hB1);
    chk("full.pend2", pend, 0);
    chk("full.ready_back", lsu_ready, 1);
    tick();
    chk("full.drained", WE3, 0);
    chk("full.perr", proto_err, 0);

    // Starvation
    alu_we = 1; alu_rd = 1; alu_wd = 32'h1;
    lsu_valid = 1; lsu_rd = 20; lsu_wd = 32'hC0;
    tick(); lsu_valid = 0;
    chk("stv.a3_1", A3, 1);
    chk("stv.pend", pend, 32'h0010_0000);
    chk("stv.stall_a", alu_stall, 0);
    for (int k = 2; k <= 4; k++) begin
      alu_rd = 5'(k); alu_wd = 32'(k);
      tick();
      chk("stv.stall_lo", alu_stall, 0);
      chk("stv.a3", A3, 5'(k));
    end
    alu_rd = 5; alu_wd = 32'h5;
    tick();
    chk("stv.stall_hi", alu_stall, 1);
    chk("stv.perr_pre", proto_err, 0);
    wr("stv.alu5", 1, 5, 32'h5);
    alu_rd = 6; alu_wd = 32'h6;
    tick();
    wr("stv.grant", 1, 20, 32'hC0);
    chk("stv.perr", proto_err, 1);
    chk("stv.stall_clr", alu_stall, 0);
    chk("stv.pend_clr", pend, 0);
    alu_rd = 7; alu_wd = 32'h7;
    tick(); alu_we = 0;
    wr("stv.after", 1, 7, 32'h7);
    chk("stv.perr_sticky", proto_err, 1);
    tick();

    // x0 write from the LSU
    lsu_valid = 1; lsu_rd = 0; lsu_wd = 32'h55;
    #1 chk("x0.ready", lsu_ready, 1);
    tick(); lsu_valid = 0;
`ifdef RF_WB_X0_DROP_EN
    chk("x0.we", WE3, 0);
`else
    wr("x0", 1, 0, 32'h55);
`endif
    chk("x0.pend", pend, 0);
    tick();

    // Reset mid-operation discards the queue
    alu_we = 1; alu_rd = 4; alu_wd = 32'h44;
    lsu_valid = 1; lsu_rd = 8; lsu_wd = 32'h88;
    tick();
    chk("mid.pend", pend, 32'h100);
    alu_we = 0; lsu_valid = 0; RST = 1;
    tick();
    wr("mid.rst", 0, 0, 0);
    chk("mid.pend_rst", pend, 0);
    chk("mid.perr_rst", proto_err, 0);
    chk("mid.ready_rst", lsu_ready, 0);
    RST = 0;
    tick();
    chk("mid.no_write", WE3, 0);
    chk("mid.ready", lsu_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the shared single write port (WE3/A3/WD3) of the 32-entry register file. It merges two write-back sources, the ALU (fixed-latency, no back-pressure) and the LSU (variable-latency loads, valid/ready). LSU results that lose arbitration are held in a small in-order queue, and a starvation guard bounds their wait. It sits between the execute/memory stages and the register file, and exports a pending-destination bitmap that issue logic uses for load-use hazard detection.

## Interface
- A_WIDTH, 5, register address width; the file has 2**A_WIDTH entries.
- D_WIDTH, 32, data width.
- DEPTH, 2, LSU queue depth; must be a power of two and at least 2.
- STARVE_MAX, 4, maximum number of cycles a queued LSU head may lose to the ALU before forced priority.
- CLK  in  1  clock; every register updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- alu_we  in  1  ALU write-back request; there is no ready signal, so it is always taken unless dropped (see Operation).
- alu_rd  in  A_WIDTH  ALU destination register.
- alu_wd  in  D_WIDTH  ALU write data.
- alu_stall  out  1  request to upstream to hold the ALU write-back this cycle.
- lsu_valid  in  1  LSU write-back request.
- lsu_ready  out  1  arbiter can accept an LSU request.
- lsu_rd  in  A_WIDTH  LSU destination register.
- lsu_wd  in  D_WIDTH  LSU write data.
- WE3  out  1  register file write enable; registered.
- A3  out  A_WIDTH  register file write address; registered.
- WD3  out  D_WIDTH  register file write data; registered.
- pend  out  2**A_WIDTH  bit r is set while a queued LSU write to register r has not yet been granted.
- proto_err  out  1  sticky flag; set when alu_we is high while alu_stall is high.

## Operation
- The LSU handshake completes when lsu_valid and lsu_ready are both high.
- lsu_ready is high when RST is low and the queue count is below DEPTH. It does not depend on lsu_valid.
- Priority each cycle, highest first:
  - alu_stall high: the queue head is granted. Any alu_we in this cycle is dropped and sets proto_err.
  - alu_we high: the ALU is granted. An accepted LSU request is enqueued.
  - Queue non-empty: the queue head is granted. An accepted LSU request is enqueued behind it.
  - Queue empty and LSU handshake: the LSU request bypasses the queue and is granted directly.
  - Otherwise there is no grant.
- A grant loads {WE3=1, A3, WD3} on the next edge. With no grant, WE3 is 0 and A3/WD3 hold their previous values.
- Queue ordering is strict FIFO. Push and pop may occur in the same cycle, and the count is unchanged in that case.
- age counter:
  - Increments when the queue is non-empty and the head is not granted.
  - Clears on a head pop or when the queue is empty.
  - Saturates at STARVE_MAX.
- alu_stall = (age == STARVE_MAX). It is combinational from the age register.
- pend is the OR of one-hot(rd) over the valid queue entries, combinational from queue state. Bypassed requests never appear in pend.
- The arbiter does not enforce write-after-write ordering between the ALU and the LSU. Issue logic must use pend to avoid it.
- Reset values: WE3=0, A3=0, WD3=0, queue empty, age=0, alu_stall=0, lsu_ready=0 while RST is high, pend=0, proto_err=0.
- Reset mid-operation discards all queued entries and any in-flight grant.

## Timing
- Latency from accepted request to WE3 is 1 cycle for a bypass or an ALU grant. For a queued entry it is 1 cycle after its grant.
- Queue full: lsu_ready is low in the same cycle the count reaches DEPTH. It rises in the cycle after the pop that frees a slot.
- Worst-case wait for the queue head is STARVE_MAX + 1 cycles from reaching the head to its grant.
- Throughput is one register-file write per cycle.

## Configuration
- RF_WB_X0_DROP_EN defined:
  - A request with rd==0 from either source is consumed. The LSU handshake completes normally.
  - The request is never enqueued, never granted and never sets pend bit 0. WE3 stays low for it.
  - The drop does not count as a grant for ALU/LSU priority purposes.
- RF_WB_X0_DROP_EN undefined: requests with rd==0 are treated like any other register.

## Test plan
- Reset: hold RST for 2 cycles with lsu_valid=1 -> lsu_ready=0 and WE3=0 throughout; one cycle after RST falls, lsu_ready=1.
- Bypass: queue empty, LSU rd=5, wd=0xDEADBEEF -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; pend stays 0.
- Conflict:
  - Stimulus: ALU rd=3/0x11 and LSU rd=7/0x22 in the same cycle, then idle.
  - Response: WE3 writes 3/0x11, then 7/0x22 on the following cycle.
  - pend[7]=1 for exactly one cycle.
- Full: alu_we held high and 2 LSU requests accepted -> lsu_ready=0; further lsu_valid is not accepted and the queue contents are unchanged.
- Starvation (STARVE_MAX=4):
  - Stimulus: alu_we held high continuously with one LSU entry queued.
  - Response: alu_stall rises after 4 lost cycles; that cycle grants the LSU entry and sets proto_err.
  - After that cycle: age=0 and alu_stall=0.
- X0 drop, with RF_WB_X0_DROP_EN defined: LSU rd=0 -> handshake completes, WE3 stays 0 and pend stays 0. Without the macro: WE3=1, A3=0.
